// File: rtl/axi_read_arbiter.sv
// Two-port round-robin arbiter for the core's shared AXI read channel.
// One fixed-length INCR line burst is outstanding at a time; R beats are steered to the winner.
module axi_read_arbiter #(
  parameter int unsigned ID_WIDTH   = 13,
  parameter int unsigned ADDR_WIDTH = 64,
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned BURST_LEN  = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req0_valid,
  input  logic [ADDR_WIDTH-1:0] req0_addr,
  output logic                  req0_ready,
  output logic                  resp0_valid,
  output logic [DATA_WIDTH-1:0] resp0_data,
  output logic                  resp0_last,
  output logic                  resp0_err,
  input  logic                  req1_valid,
  input  logic [ADDR_WIDTH-1:0] req1_addr,
  output logic                  req1_ready,
  output logic                  resp1_valid,
  output logic [DATA_WIDTH-1:0] resp1_data,
  output logic                  resp1_last,
  output logic                  resp1_err,
  output logic [ID_WIDTH-1:0]   m_axi_arid,
  output logic [ADDR_WIDTH-1:0] m_axi_araddr,
  output logic [7:0]            m_axi_arlen,
  output logic [2:0]            m_axi_arsize,
  output logic [1:0]            m_axi_arburst,
  output logic                  m_axi_arlock,
  output logic [3:0]            m_axi_arcache,
  output logic [2:0]            m_axi_arprot,
  output logic                  m_axi_arvalid,
  input  logic                  m_axi_arready,
  input  logic [ID_WIDTH-1:0]   m_axi_rid,
  input  logic [DATA_WIDTH-1:0] m_axi_rdata,
  input  logic [1:0]            m_axi_rresp,
  input  logic                  m_axi_rlast,
  input  logic                  m_axi_rvalid,
  output logic                  m_axi_rready
);

  localparam int unsigned LineBytes = BURST_LEN * DATA_WIDTH / 8;
  localparam int unsigned LineLsb   = $clog2(LineBytes);
  localparam int unsigned CntWidth  = $clog2(BURST_LEN) + 1;
  localparam int unsigned LineWidth = ADDR_WIDTH - LineLsb;

  typedef enum logic [1:0] {StIdle, StAddr, StData} state_e;

  state_e                state_q;
  logic                  grant_q;
  logic                  last_grant_q;
  logic [LineWidth-1:0]  line_q;
  logic [CntWidth-1:0]   beat_cnt_q;

  logic                  any_req;
  logic                  grant_d;
  logic                  beat;
  logic                  final_beat;
  logic                  past_final;
  logic                  len_err;
  logic                  id_err;
  logic                  err;
  logic                  unused_offset;

  // Byte offsets within the line never reach the bus.
  assign unused_offset = ^{req0_addr[LineLsb-1:0], req1_addr[LineLsb-1:0]};

  always_comb begin
    any_req = req0_valid | req1_valid;
    grant_d = 1'b0;
    if (req0_valid && req1_valid) begin
      grant_d = ~last_grant_q;
    end else begin
      grant_d = req1_valid;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      grant_q      <= 1'b0;
      last_grant_q <= 1'b1;
      line_q       <= '0;
      beat_cnt_q   <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (any_req) begin
            grant_q <= grant_d;
            line_q  <= grant_d ? req1_addr[ADDR_WIDTH-1:LineLsb] : req0_addr[ADDR_WIDTH-1:LineLsb];
            state_q <= StAddr;
          end
        end
        StAddr: begin
          beat_cnt_q <= '0;
          if (m_axi_arready) begin
            state_q <= StData;
          end
        end
        StData: begin
          if (m_axi_rvalid) begin
            // Saturate so an over-long burst keeps flagging errors instead of wrapping.
            if (beat_cnt_q != '1) begin
              beat_cnt_q <= beat_cnt_q + CntWidth'(1);
            end
            if (m_axi_rlast) begin
              last_grant_q <= grant_q;
              state_q      <= StIdle;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  always_comb begin
    beat       = m_axi_rvalid && (state_q == StData);
    final_beat = beat_cnt_q == CntWidth'(BURST_LEN - 1);
    past_final = beat_cnt_q >= CntWidth'(BURST_LEN - 1);
    len_err    = m_axi_rlast ? !final_beat : past_final;
    id_err     = m_axi_rid != ID_WIDTH'(grant_q);
    err        = (m_axi_rresp != 2'b00) || id_err || len_err;

    resp0_valid = beat & ~grant_q;
    resp1_valid = beat & grant_q;
    resp0_data  = m_axi_rdata;
    resp1_data  = m_axi_rdata;
    resp0_last  = resp0_valid & m_axi_rlast;
    resp1_last  = resp1_valid & m_axi_rlast;
    resp0_err   = resp0_valid & err;
    resp1_err   = resp1_valid & err;

    req0_ready = (state_q == StIdle) && any_req && !grant_d;
    req1_ready = (state_q == StIdle) && any_req && grant_d;

    m_axi_arvalid = state_q == StAddr;
    m_axi_araddr  = {line_q, {LineLsb{1'b0}}};
    m_axi_arid    = ID_WIDTH'(grant_q);
    m_axi_arlen   = 8'(BURST_LEN - 1);
    m_axi_arsize  = 3'($clog2(DATA_WIDTH / 8));
    m_axi_arburst = 2'b01;
    m_axi_arlock  = 1'b0;
    m_axi_arcache = 4'b0011;
    m_axi_arprot  = 3'b000;
    m_axi_rready  = state_q == StData;
  end

endmodule
